// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: BEOp width codes, FSM states
// and helpers that classify an access by width and alignment.
package mem_access_unit_pkg;

   localparam logic [2:0] BE_SW  = 3'b000;
   localparam logic [2:0] BE_SH  = 3'b001;
   localparam logic [2:0] BE_SB  = 3'b010;
   localparam logic [2:0] BE_LW  = 3'b011;
   localparam logic [2:0] BE_LHU = 3'b100;
   localparam logic [2:0] BE_LH  = 3'b101;
   localparam logic [2:0] BE_LBU = 3'b110;
   localparam logic [2:0] BE_LB  = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      WID_BYTE = 2'd0,
      WID_HALF = 2'd1,
      WID_WORD = 2'd2
   } width_t;

   function automatic width_t op_width(input logic [2:0] op);
      case (op)
         BE_SW, BE_LW:         return WID_WORD;
         BE_SH, BE_LHU, BE_LH: return WID_HALF;
         default:              return WID_BYTE;
      endcase
   endfunction

   function automatic logic op_aligned(input logic [2:0] op, input logic [1:0] addr_lo);
      case (op_width(op))
         WID_WORD: return addr_lo == 2'b00;
         WID_HALF: return ~addr_lo[0];
         default:  return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store byte enables / replicated write data, and load
// extraction with sign or zero extension.
module mem_lane_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  st_op,
   input  logic [1:0]  st_addr,
   input  logic        st_we,
   input  logic [31:0] st_wdata,
   output logic [3:0]  st_be,
   output logic [31:0] st_wdata_rep,
   input  logic [2:0]  ld_op,
   input  logic [1:0]  ld_addr,
   input  logic [31:0] ld_word,
   output logic [31:0] ld_data
);

   logic [15:0] ld_half;
   logic [7:0]  ld_byte;

   // Reads always fetch the full word; only stores narrow the enables.
   always_comb begin
      st_be        = 4'b1111;
      st_wdata_rep = st_wdata;
      if (st_we) begin
         case (op_width(st_op))
            WID_HALF: begin
               st_be        = st_addr[1] ? 4'b1100 : 4'b0011;
               st_wdata_rep = {2{st_wdata[15:0]}};
            end
            WID_BYTE: begin
               st_be        = 4'b0001 << st_addr;
               st_wdata_rep = {4{st_wdata[7:0]}};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ld_half = ld_addr[1] ? ld_word[31:16] : ld_word[15:0];
      case (ld_addr)
         2'd0:    ld_byte = ld_word[7:0];
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         default: ld_byte = ld_word[31:24];
      endcase
      case (ld_op)
         BE_LB:         ld_data = {{24{ld_byte[7]}}, ld_byte};
         BE_LBU, BE_SB: ld_data = {24'h0, ld_byte};
         BE_LH:         ld_data = {{16{ld_half[15]}}, ld_half};
         BE_LHU, BE_SH: ld_data = {16'h0, ld_half};
         default:       ld_data = ld_word;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: one request/ack bus beat per access, pipeline stall.
// Optional MEM_TIMEOUT_EN adds a REQ watchdog and the sticky bus_err_o flag.
//
// state   | meaning
// IDLE    | waiting for an aligned MemRead/MemWrite; misaligned ones pulse misalign_o
// REQ     | bus_req_o high, request fields frozen until bus_ack_i (or watchdog)
// DONE    | one unstalled cycle so the pipeline moves past this instruction
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              MemRead_i,
   input  logic              MemWrite_i,
   input  logic [2:0]        BEOp_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic [31:0]       rdata_o,
   output logic              stall_o,
   output logic              misalign_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [3:0]        bus_be_o,
   output logic [31:0]       bus_wdata_o,
   input  logic              bus_ack_i,
   input  logic [31:0]       bus_rdata_i
`ifdef MEM_TIMEOUT_EN
   ,
   output logic              bus_err_o
`endif
);

   state_t      state;
   logic [2:0]  beop_q;
   logic [1:0]  addr_lo_q;
   logic        access;
   logic        aligned;
   logic [3:0]  st_be;
   logic [31:0] st_wdata_rep;
   logic [31:0] ld_data;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] req_cnt;
`endif

   assign access  = MemRead_i | MemWrite_i;
   assign aligned = op_aligned(BEOp_i, addr_i[1:0]);

   // Gated by rst_i so a reset mid-transaction releases the pipeline at once.
   assign stall_o = ~rst_i & (((state == ST_IDLE) & access & aligned) | (state == ST_REQ));

   mem_lane_align u_lane (
      .st_op        (BEOp_i),
      .st_addr      (addr_i[1:0]),
      .st_we        (MemWrite_i),
      .st_wdata     (wdata_i),
      .st_be        (st_be),
      .st_wdata_rep (st_wdata_rep),
      .ld_op        (beop_q),
      .ld_addr      (addr_lo_q),
      .ld_word      (bus_rdata_i),
      .ld_data      (ld_data)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         rdata_o     <= 32'h0;
         misalign_o  <= 1'b0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_be_o    <= 4'h0;
         bus_wdata_o <= 32'h0;
         beop_q      <= 3'b000;
         addr_lo_q   <= 2'b00;
`ifdef MEM_TIMEOUT_EN
         req_cnt     <= '0;
         bus_err_o   <= 1'b0;
`endif
      end else begin
         misalign_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (access && aligned) begin
                  state       <= ST_REQ;
                  bus_req_o   <= 1'b1;
                  bus_we_o    <= MemWrite_i;
                  bus_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                  bus_be_o    <= st_be;
                  bus_wdata_o <= st_wdata_rep;
                  beop_q      <= BEOp_i;
                  addr_lo_q   <= addr_i[1:0];
`ifdef MEM_TIMEOUT_EN
                  req_cnt     <= '0;
`endif
               end else if (access) begin
                  misalign_o <= 1'b1;
                  if (!MemWrite_i)
                     rdata_o <= 32'h0;
               end
            end
            ST_REQ: begin
               if (bus_ack_i) begin
                  bus_req_o <= 1'b0;
                  if (!bus_we_o)
                     rdata_o <= ld_data;
                  state <= ST_DONE;
               end
`ifdef MEM_TIMEOUT_EN
               else if (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  bus_req_o <= 1'b0;
                  rdata_o   <= 32'h0;
                  bus_err_o <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  req_cnt <= req_cnt + 1'b1;
               end
`endif
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed vectors plus randomized
// loads/stores checked against a byte-lane reference model.
module tb_mem_access_unit;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        MemRead_i, MemWrite_i;
   logic [2:0]  BEOp_i;
   logic [31:0] addr_i, wdata_i, rdata_o;
   logic        stall_o, misalign_o, bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
   logic [3:0]  bus_be_o;
   logic        bus_ack_i;
`ifdef MEM_TIMEOUT_EN
   logic        bus_err_o;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] rdata_model = 32'h0;

   mem_access_unit dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .MemRead_i   (MemRead_i),
      .MemWrite_i  (MemWrite_i),
      .BEOp_i      (BEOp_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .rdata_o     (rdata_o),
      .stall_o     (stall_o),
      .misalign_o  (misalign_o),
      .bus_req_o   (bus_req_o),
      .bus_we_o    (bus_we_o),
      .bus_addr_o  (bus_addr_o),
      .bus_be_o    (bus_be_o),
      .bus_wdata_o (bus_wdata_o),
      .bus_ack_i   (bus_ack_i),
      .bus_rdata_i (bus_rdata_i)
`ifdef MEM_TIMEOUT_EN
      ,
      .bus_err_o   (bus_err_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   function automatic int width_bytes(input logic [2:0] op);
      if (op == 3'd0 || op == 3'd3) return 4;
      if (op == 3'd1 || op == 3'd4 || op == 3'd5) return 2;
      return 1;
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] addr,
                                          input logic [31:0] word);
      int nb;
      logic [31:0] v;
      nb = width_bytes(op);
      v  = word >> (8 * (addr % 4));
      if (nb == 4) return word;
      if (nb == 2) begin
         v = v & 32'h0000FFFF;
         if (op == 3'd5 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else begin
         v = v & 32'h000000FF;
         if (op == 3'd7 && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      return v;
   endfunction

   task automatic do_access(input bit we, input bit re, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rword, input int waits);
      int nb, n, stalls;
      bit ok;
      logic [3:0]  be_exp;
      logic [31:0] wd_exp;
      nb = width_bytes(op);
      ok = (addr % nb) == 0;
      if (!we) be_exp = 4'hF;
      else if (nb == 4) be_exp = 4'hF;
      else if (nb == 2) be_exp = 4'(3 << (addr % 4));
      else be_exp = 4'(1 << (addr % 4));
      if (nb == 4) wd_exp = wdata;
      else if (nb == 2) wd_exp = {16'h0, wdata[15:0]} * 32'h00010001;
      else wd_exp = {24'h0, wdata[7:0]} * 32'h01010101;

      @(negedge clk_i);
      MemWrite_i = we; MemRead_i = re; BEOp_i = op; addr_i = addr; wdata_i = wdata;
      #1;
      checks++;
      if (stall_o !== ok) begin
         errors++; $display("FAIL idle_stall: got %b expected %b (op %0d addr %h)", stall_o, ok, op, addr);
      end
      if (!ok) begin
         if (!we) rdata_model = 32'h0;
         @(posedge clk_i); #1;
         MemWrite_i = 1'b0; MemRead_i = 1'b0;
         checks++;
         if (misalign_o !== 1'b1) begin errors++; $display("FAIL misalign_pulse: got %b expected 1", misalign_o); end
         checks++;
         if (bus_req_o !== 1'b0) begin errors++; $display("FAIL misalign_no_req: got %b expected 0", bus_req_o); end
         checks++;
         if (rdata_o !== rdata_model) begin errors++; $display("FAIL misalign_rdata: got %h expected %h", rdata_o, rdata_model); end
         @(posedge clk_i); #1;
         checks++;
         if (misalign_o !== 1'b0) begin errors++; $display("FAIL misalign_one_cycle: got %b expected 0", misalign_o); end
      end else begin
         stalls = 1;
         n = 0;
         @(posedge clk_i); #1;
         while (bus_req_o === 1'b1 && n <= waits + 4) begin
            if (stall_o === 1'b1) stalls++;
            checks++;
            if ({bus_we_o, bus_addr_o, bus_be_o} !== {we, addr & 32'hFFFFFFFC, be_exp}) begin
               errors++;
               $display("FAIL req_fields: got we=%b addr=%h be=%b expected we=%b addr=%h be=%b",
                        bus_we_o, bus_addr_o, bus_be_o, we, addr & 32'hFFFFFFFC, be_exp);
            end
            if (we) begin
               checks++;
               if (bus_wdata_o !== wd_exp) begin errors++; $display("FAIL req_wdata: got %h expected %h", bus_wdata_o, wd_exp); end
            end
            if (n == waits) begin bus_ack_i = 1'b1; bus_rdata_i = rword; end
            else begin bus_ack_i = 1'b0; bus_rdata_i = $urandom; end
            @(posedge clk_i); #1;
            bus_ack_i = 1'b0;
            n++;
         end
         checks++;
         if (n != waits + 1) begin errors++; $display("FAIL req_cycles: got %0d expected %0d", n, waits + 1); end
         if (!we) rdata_model = extend(op, addr, rword);
         checks++;
         if (stall_o !== 1'b0) begin errors++; $display("FAIL done_stall: got %b expected 0", stall_o); end
         checks++;
         if (stalls != waits + 2) begin errors++; $display("FAIL stall_len: got %0d expected %0d", stalls, waits + 2); end
         checks++;
         if (rdata_o !== rdata_model) begin
            errors++; $display("FAIL rdata: got %h expected %h (op %0d addr %h)", rdata_o, rdata_model, op, addr);
         end
         checks++;
         if (misalign_o !== 1'b0) begin errors++; $display("FAIL aligned_no_misalign: got %b expected 0", misalign_o); end
         MemWrite_i = 1'b0; MemRead_i = 1'b0;
         @(posedge clk_i); #1;
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      MemRead_i = 1'b1; MemWrite_i = 1'b0; BEOp_i = 3'd3; addr_i = 32'h0; wdata_i = 32'h0;
      bus_ack_i = 1'b0; bus_rdata_i = 32'h0;
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if ({rdata_o, bus_addr_o, bus_be_o, bus_wdata_o} !== 100'h0) begin
         errors++; $display("FAIL reset_data: got rdata=%h addr=%h be=%b wdata=%h expected 0", rdata_o, bus_addr_o, bus_be_o, bus_wdata_o);
      end
      checks++;
      if ({bus_req_o, bus_we_o, misalign_o, stall_o} !== 4'b0) begin
         errors++; $display("FAIL reset_ctrl: got req=%b we=%b mis=%b stall=%b expected 0", bus_req_o, bus_we_o, misalign_o, stall_o);
      end
`ifdef MEM_TIMEOUT_EN
      checks++;
      if (bus_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus_err_o); end
`endif
      @(negedge clk_i);
      MemRead_i = 1'b0;
      rst_i = 1'b0;
      rdata_model = 32'h0;
   endtask

   task automatic test_directed();
      do_access(1, 0, 3'd0, 32'h104, 32'hDEADBEEF, 32'h0, 0);
      do_access(1, 0, 3'd2, 32'h103, 32'h000000A5, 32'h0, 1);
      do_access(0, 1, 3'd7, 32'h102, 32'h0, 32'h1280FF34, 0);
      checks++;
      if (rdata_o !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_value: got %h expected ffffff80", rdata_o); end
      do_access(0, 1, 3'd6, 32'h102, 32'h0, 32'h1280FF34, 2);
      checks++;
      if (rdata_o !== 32'h00000080) begin errors++; $display("FAIL lbu_value: got %h expected 00000080", rdata_o); end
      do_access(0, 1, 3'd5, 32'h102, 32'h0, 32'h80015A5A, 3);
      checks++;
      if (rdata_o !== 32'hFFFF8001) begin errors++; $display("FAIL lh_value: got %h expected ffff8001", rdata_o); end
      do_access(1, 0, 3'd1, 32'h105, 32'h1234, 32'h0, 0);
      do_access(0, 1, 3'd3, 32'h101, 32'h0, 32'h0, 0);
      checks++;
      if (rdata_o !== 32'h0) begin errors++; $display("FAIL lw_misalign_clear: got %h expected 0", rdata_o); end
   endtask

   task automatic test_idle_ack();
      @(negedge clk_i);
      bus_ack_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
      repeat (2) @(negedge clk_i);
      bus_ack_i = 1'b0;
      #1;
      checks++;
      if ({bus_req_o, stall_o} !== 2'b00 || rdata_o !== rdata_model) begin
         errors++; $display("FAIL idle_ack_ignored: got req=%b stall=%b rdata=%h expected 0 0 %h", bus_req_o, stall_o, rdata_o, rdata_model);
      end
   endtask

   task automatic test_random();
      logic [2:0]  op;
      logic [31:0] addr;
      bit we, re;
      int sel;
      for (int i = 0; i < 80; i++) begin
         op   = 3'($urandom_range(0, 7));
         addr = 32'h1000 + $urandom_range(0, 255);
         sel  = $urandom_range(0, 3);
         if (sel == 0) begin we = 1; re = 1; end
         else begin we = (op <= 3'd2); re = !we; end
         do_access(we, re, op, addr, $urandom, $urandom, $urandom_range(0, 4));
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_access(0, 1, 3'd3, 32'h200, 32'h0, 32'h13579BDF, 0);
      @(negedge clk_i);
      MemRead_i = 1'b1; MemWrite_i = 1'b0; BEOp_i = 3'd3; addr_i = 32'h204;
      @(posedge clk_i); #1;
      checks++;
      if (bus_req_o !== 1'b1) begin errors++; $display("FAIL mid_req_up: got %b expected 1", bus_req_o); end
      #2 rst_i = 1'b1;
      #1;
      rdata_model = 32'h0;
      checks++;
      if ({bus_req_o, stall_o} !== 2'b00) begin
         errors++; $display("FAIL mid_reset_drop: got req=%b stall=%b expected 0 0", bus_req_o, stall_o);
      end
      checks++;
      if (rdata_o !== rdata_model) begin errors++; $display("FAIL mid_reset_rdata: got %h expected 0", rdata_o); end
      MemRead_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      n = 0;
      do_access(0, 1, 3'd4, 32'h20A, 32'h0, 32'hBEEF1234, 1);
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      do_access(0, 1, 3'd3, 32'h300, 32'h0, 32'h11223344, 0);
      @(negedge clk_i);
      MemRead_i = 1'b1; MemWrite_i = 1'b0; BEOp_i = 3'd3; addr_i = 32'h304;
      @(posedge clk_i); #1;
      n = 0;
      while (bus_req_o === 1'b1 && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      rdata_model = 32'h0;
      checks++;
      if (n != 64) begin errors++; $display("FAIL timeout_len: got %0d expected 64", n); end
      checks++;
      if (bus_err_o !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", bus_err_o); end
      checks++;
      if (rdata_o !== 32'h0 || stall_o !== 1'b0) begin
         errors++; $display("FAIL timeout_done: got rdata=%h stall=%b expected 0 0", rdata_o, stall_o);
      end
      MemRead_i = 1'b0;
      @(posedge clk_i); #1;
      do_access(1, 0, 3'd0, 32'h308, 32'h5555AAAA, 32'h0, 0);
      checks++;
      if (bus_err_o !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", bus_err_o); end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_idle_ack();
      test_random();
      test_reset_mid();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
